// File: rtl/motor_pwm_if.sv
// Avalon-MM slave bus bundle for motor_pwm_slave.
// The master drives the strobes; the slave returns registered readdata.
interface motor_pwm_if #(
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] address;
  logic                  write;
  logic [31:0]           writedata;
  logic                  read;
  logic [31:0]           readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/motor_pwm_slave.sv
// Multi-channel H-bridge PWM controller with per-channel slew-rate limiting
// and direction reversal gated on reaching zero duty.
module motor_pwm_slave #(
  parameter int NUM_MOTORS = 6,
  parameter int DUTY_WIDTH = 5,
  parameter int CLK_DIV    = 1,
  parameter int RAMP_DIV   = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  motor_pwm_if.slave            bus,
  output logic [NUM_MOTORS-1:0] pwm,
  output logic [NUM_MOTORS-1:0] dir
);

  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int CTRL_W  = 2 * NUM_MOTORS;

  function automatic logic [DUTY_WIDTH-1:0] step_toward(
    input logic [DUTY_WIDTH-1:0] cur,
    input logic [DUTY_WIDTH-1:0] tgt
  );
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    return cur;
  endfunction

  logic [PRESC_W-1:0]    presc;
  logic [DUTY_WIDTH-1:0] pcnt;
  logic [RAMP_W-1:0]     rcnt;
  logic                  tick;
  logic                  boundary;
  logic                  ramp_step;

  logic [CTRL_W-1:0]     ctrl;
  logic [DUTY_WIDTH-1:0] target [NUM_MOTORS];
  logic [DUTY_WIDTH-1:0] duty   [NUM_MOTORS];
  logic [DUTY_WIDTH-1:0] eff    [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] enable;
  logic [NUM_MOTORS-1:0] req_dir;
  logic [NUM_MOTORS-1:0] busy;
  logic [31:0]           rd_val;

  assign tick      = (presc == PRESC_W'(CLK_DIV - 1));
  assign boundary  = tick && (pcnt == '1);
  assign ramp_step = boundary && (rcnt == RAMP_W'(RAMP_DIV - 1));

  // Timebase: prescaler -> PWM counter -> ramp divider
  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
      pcnt  <= '0;
      rcnt  <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick)     pcnt <= pcnt + 1'b1;
      if (boundary) rcnt <= ramp_step ? '0 : rcnt + 1'b1;
    end
  end

  // A pending reversal forces the effective target to zero until dir flips.
  always_comb begin
    for (int i = 0; i < NUM_MOTORS; i++) begin
      enable[i]  = ctrl[2*i];
      req_dir[i] = ctrl[2*i+1];
      eff[i]     = (enable[i] && (req_dir[i] == dir[i])) ? target[i] : '0;
      busy[i]    = (duty[i] != eff[i]) || (dir[i] != req_dir[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) target[i] <= '0;
    end else if (bus.write) begin
      if (bus.address == '0) ctrl <= bus.writedata[CTRL_W-1:0];
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (bus.address == ADDR_WIDTH'(i + 2)) target[i] <= bus.writedata[DUTY_WIDTH-1:0];
      end
    end
  end

  // Duty/dir only move on ramp steps (period boundaries), except disable.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) duty[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (!enable[i])     duty[i] <= '0;
        else if (ramp_step) duty[i] <= step_toward(duty[i], eff[i]);
        if (ramp_step && (duty[i] == '0) && (req_dir[i] != dir[i])) dir[i] <= req_dir[i];
      end
    end
  end

  // Output stage: registered compare
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++) pwm[i] <= enable[i] && (pcnt < duty[i]);
    end
  end

  always_comb begin
    rd_val = '0;
    if (bus.address == ADDR_WIDTH'(0)) begin
      rd_val[CTRL_W-1:0] = ctrl;
    end else if (bus.address == ADDR_WIDTH'(1)) begin
      rd_val[NUM_MOTORS-1:0]  = busy;
      rd_val[16+:NUM_MOTORS]  = dir;
    end else begin
      for (int i = 0; i < NUM_MOTORS; i++) begin
        if (bus.address == ADDR_WIDTH'(i + 2)) rd_val[DUTY_WIDTH-1:0] = target[i];
      end
    end
  end

  // Read stage: one-cycle latency, held until the next read
  always_ff @(posedge clk) begin
    if (reset)         bus.readdata <= '0;
    else if (bus.read) bus.readdata <= rd_val;
  end

endmodule

// File: tb/tb_motor_pwm_slave.sv
// Directed bench for motor_pwm_slave with RAMP_DIV = 1 (one 32-clk period per duty step).
module tb_motor_pwm_slave;
  localparam int NM = 6;
  localparam int DW = 5;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NM-1:0] pwm;
  logic [NM-1:0] dir;
  int            cyc = 0;
  int            checks = 0;
  int            passes = 0;

  motor_pwm_if #(.ADDR_WIDTH(AW)) bus_if ();

  motor_pwm_slave #(
    .NUM_MOTORS(NM), .DUTY_WIDTH(DW), .CLK_DIV(1), .RAMP_DIV(1), .ADDR_WIDTH(AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave),
    .pwm   (pwm),
    .dir   (dir)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address   = AW'(a);
    bus_if.writedata = d;
    bus_if.write     = 1'b1;
    @(negedge clk);
    bus_if.write     = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    @(negedge clk);
    bus_if.address = AW'(a);
    bus_if.read    = 1'b1;
    @(negedge clk);
    bus_if.read    = 1'b0;
    d = bus_if.readdata;
  endtask

  task automatic poll_clear(input int bitn, input int bound, output logic ok);
    logic [31:0] s;
    int start;
    start = cyc;
    ok = 1'b0;
    while (!ok && (cyc - start) < bound) begin
      rd(1, s);
      if (!s[bitn]) ok = 1'b1;
    end
  endtask

  task automatic win(input int ch, output int cnt);
    cnt = 0;
    repeat (32) begin
      @(negedge clk);
      if (pwm[ch]) cnt++;
    end
  endtask

  initial begin
    logic [31:0] d;
    logic        ok;
    logic        found;
    logic        flip_pwm;
    int          t0, el, cnt, other, flip_cyc, last_hi;

    reset = 1'b1;
    bus_if.address = '0; bus_if.write = 1'b0; bus_if.writedata = '0; bus_if.read = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_readdata", bus_if.readdata, 32'h0);
    reset = 1'b0;

    // Reset state: every register reads zero, outputs idle
    for (int a = 0; a < 8; a++) begin
      rd(a, d);
      check($sformatf("reset_rd_addr%0d", a), d, 32'h0);
    end
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (pwm != '0 || dir != '0) cnt++;
    end
    check("reset_outputs_idle", cnt, 0);

    // Channel 0 ramps to duty 3
    wr(2, 32'd3);
    wr(0, 32'h1);
    t0 = cyc;
    rd(1, d);
    check("ch0_busy_after_en", d, 32'h1);
    poll_clear(0, 200, ok);
    el = cyc - t0;
    check("ch0_ramp_done", ok, 1);
    check("ch0_ramp_time", (el >= 62 && el <= 102) ? 1 : 0, 1);
    win(0, cnt);
    check("ch0_pwm_high_3", cnt, 3);
    other = 0;
    repeat (32) begin
      @(negedge clk);
      if (pwm[NM-1:1] != '0) other++;
    end
    check("others_idle", other, 0);
    rd(1, d);
    check("ch0_status_idle", d, 32'h0);

    // Reverse channel 0: ramp down, flip at zero, ramp back up
    wr(0, 32'h3);
    t0 = cyc; found = 1'b0; last_hi = t0; flip_cyc = t0; flip_pwm = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      @(negedge clk);
      if (dir[0]) begin
        found = 1'b1; flip_cyc = cyc; flip_pwm = pwm[0];
      end else if (pwm[0]) begin
        last_hi = cyc;
      end
    end
    check("rev_dir_flipped", found, 1);
    check("rev_flip_time", ((flip_cyc - t0) >= 92 && (flip_cyc - t0) <= 134) ? 1 : 0, 1);
    check("rev_quiet_before_flip", ((flip_cyc - last_hi) >= 30) ? 1 : 0, 1);
    check("rev_pwm_at_flip", flip_pwm, 0);
    poll_clear(0, 200, ok);
    check("rev_ramp_done", ok, 1);
    rd(1, d);
    check("rev_status", d, 32'h0001_0000);
    win(0, cnt);
    check("rev_pwm_high_3", cnt, 3);

    // Channel 2 to duty 10, then emergency stop
    wr(4, 32'd10);
    wr(0, 32'h13);
    poll_clear(2, 500, ok);
    check("ch2_ramp_done", ok, 1);
    win(2, cnt);
    check("ch2_pwm_high_10", cnt, 10);
    wr(0, 32'h3);
    @(negedge clk);
    check("estop_pwm2_low", pwm[2], 0);
    win(2, cnt);
    check("estop_pwm2_stays_low", cnt, 0);
    rd(1, d);
    check("estop_status", d, 32'h0001_0000);

    // Channel 5 mid-ramp, then reset while its pwm is high
    wr(7, 32'd31);
    wr(0, 32'h403);
    repeat (12 * 32 + 8) @(negedge clk);
    rd(1, d);
    check("ch5_midramp_status", d, 32'h0001_0020);
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (pwm[5]) ok = 1'b1;
    end
    check("ch5_pwm_seen_high", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_pwm_zero", pwm, '0);
    check("rst_dir_zero", dir, '0);
    check("rst_readdata_zero", bus_if.readdata, 32'h0);
    reset = 1'b0;
    rd(7, d);
    check("rst_target5_zero", d, 32'h0);
    rd(0, d);
    check("rst_ctrl_zero", d, 32'h0);

    // Writes to STATUS and unmapped space must not disturb mapped registers
    wr(0, 32'h800);
    wr(3, 32'h15);
    wr(5, 32'hFFFF_FFE7);
    wr(6, 32'h1F);
    wr(1, 32'hFFFF_FFFF);
    wr(20, 32'hFFFF_FFFF);
    rd(0, d);  check("map_ctrl", d, 32'h800);
    rd(2, d);  check("map_t0", d, 32'h0);
    rd(3, d);  check("map_t1", d, 32'h15);
    rd(4, d);  check("map_t2", d, 32'h0);
    rd(5, d);  check("map_t3_masked", d, 32'h07);
    rd(7, d);  check("map_t5", d, 32'h0);
    rd(6, d);  check("map_t4", d, 32'h1F);
    rd(20, d); check("unmapped_rd", d, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
